write_back_unit: RTL and testbench
==================================

WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register data width; SHALL be a multiple of 8 and at least 32.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, register-file address width.
REQ-003 Parameter LOAD_TIMEOUT, default 15, maximum cycles spent waiting for load data; SHALL be at least 1.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 inValid  in  1  memory stage presents an instruction this cycle.
REQ-007 writeBackControl  in  5  [0] memToReg, [1] regWrite, [3:2] loadSize (00 word, 01 half, 10 byte, 11 word), [4] loadUnsigned.
REQ-008 writeReg  in  REG_ADDR_WIDTH  destination register.
REQ-009 result  in  DATA_WIDTH  ALU result.
REQ-010 readData  in  DATA_WIDTH  memory load data, qualified by readValid.
REQ-011 readValid  in  1  readData valid this cycle.
REQ-012 byteOffset  in  2  load address bits [1:0].
REQ-013 stall  out  1  combinational; upstream holds inputs while high.
REQ-014 regWriteEnable  out  1  registered register-file write strobe.
REQ-015 regWriteAddr  out  REG_ADDR_WIDTH  registered write address.
REQ-016 writeData  out  DATA_WIDTH  registered write data.
REQ-017 loadError  out  1  registered one-cycle pulse on load timeout.

Function
REQ-018 FSM states: IDLE, WAIT_LOAD.
REQ-019 IDLE, inValid=1, memToReg=0: next cycle regWriteEnable=regWrite and (writeReg!=0), regWriteAddr=writeReg, writeData=result; latency 1 cycle.
REQ-020 IDLE, inValid=1, memToReg=1, readValid=1: next cycle write extended readData (REQ-024), with the enable rule of REQ-019; state stays IDLE.
REQ-021 IDLE, inValid=1, memToReg=1, readValid=0: capture writeReg, writeBackControl and byteOffset; clear wait counter; enter WAIT_LOAD; no write issued.
REQ-022 stall = (IDLE and inValid and memToReg and not readValid) or (WAIT_LOAD and not readValid).
REQ-023 WAIT_LOAD: inValid ignored; on readValid=1, write extended readData using captured fields next cycle and return to IDLE; otherwise increment wait counter.
REQ-024 Load extension: word passes readData unchanged; half selects readData[15:0] when byteOffset[1]=0, else readData[31:16]; byte selects lane byteOffset of bits [31:0]; extension to DATA_WIDTH is zero if loadUnsigned=1, else sign.
REQ-025 byteOffset[0] is ignored for half loads; no alignment fault is raised.
REQ-026 When the wait counter reaches LOAD_TIMEOUT with readValid=0, the next cycle SHALL pulse loadError=1, suppress the write (regWriteEnable=0), and return to IDLE; stall deasserts in that next cycle.
REQ-027 readValid arriving in the same cycle the timeout is reached takes priority: the write occurs and loadError stays 0.
REQ-028 readValid=1 in IDLE without a pending load is ignored.
REQ-029 regWriteEnable is a single-cycle pulse per accepted instruction; it is 0 in every cycle with no completed instruction.
REQ-030 Register 0 is never written; regWriteAddr and writeData still update.

Reset
REQ-031 reset=1 at a clock edge SHALL set state=IDLE, wait counter=0, regWriteEnable=0, regWriteAddr=0, writeData=0, loadError=0.
REQ-032 Reset asserted during WAIT_LOAD SHALL abandon the pending load with no write and no loadError; stall is 0 in the cycle after reset.
REQ-033 Reset has priority over all other inputs.

Verification
REQ-034 ALU op: inValid=1, memToReg=0, regWrite=1, writeReg=3, result=0x12345678 -> next cycle regWriteEnable=1, regWriteAddr=3, writeData=0x12345678, stall=0.
REQ-035 Signed byte load, same-cycle data: readData=0x80FF7F01, byteOffset=2, loadSize=10, loadUnsigned=0, writeReg=7 -> writeData=0xFFFFFFFF; with byteOffset=1 -> 0x0000007F.
REQ-036 Delayed load: memToReg=1, readValid low 3 cycles, then readData=0x0000ABCD, half, unsigned, byteOffset=0 -> stall high exactly 3 cycles, one write of 0x0000ABCD.
REQ-037 Timeout: LOAD_TIMEOUT=4, readValid never asserted -> loadError pulses once, no regWriteEnable, state back to IDLE, next ALU op completes normally.
REQ-038 writeReg=0 with regWrite=1 -> regWriteEnable stays 0; reset asserted during WAIT_LOAD -> all outputs 0, no write.
REQ-039 DATA_WIDTH=64 build: signed half load of 0x8000 -> writeData=0xFFFFFFFFFFFF8000.

Source files
------------

// File: rtl/write_back_unit.sv
// ---------------------------------------------------------------------------
// write_back_unit
//
// Final pipeline stage.  It takes either an ALU result or memory load data,
// sign/zero-extends sub-word loads, and drives a registered register-file
// write port.  Load data that is not ready in the same cycle is waited for
// (with upstream stalled) up to a bounded number of cycles.  If it never
// arrives, the write is dropped and a one-cycle loadError pulse is raised.
//
// Parameters
//   DATA_WIDTH     register width (multiple of 8, >= 32)
//   REG_ADDR_WIDTH register-file address width
//   LOAD_TIMEOUT   wait-counter value at which a missing load is abandoned
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   inValid           instruction presented by the memory stage
//   writeBackControl  [0] memToReg, [1] regWrite, [3:2] loadSize,
//                     [4] loadUnsigned
//   writeReg          destination register
//   result            ALU result
//   readData/readValid load data and its qualifier
//   byteOffset        load address bits [1:0]
//   stall             combinational hold request to upstream
//   regWriteEnable    registered write strobe (never for register 0)
//   regWriteAddr      registered write address
//   writeData         registered write data
//   loadError         registered one-cycle pulse on load timeout
// ---------------------------------------------------------------------------
module write_back_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inValid,
  input  logic [4:0]                writeBackControl,
  input  logic [REG_ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0]     result,
  input  logic [DATA_WIDTH-1:0]     readData,
  input  logic                      readValid,
  input  logic [1:0]                byteOffset,
  output logic                      stall,
  output logic                      regWriteEnable,
  output logic [REG_ADDR_WIDTH-1:0] regWriteAddr,
  output logic [DATA_WIDTH-1:0]     writeData,
  output logic                      loadError
);

  localparam int CNT_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(LOAD_TIMEOUT);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;

  // Fields of the pending load, held while waiting for readData.
  logic [REG_ADDR_WIDTH-1:0] cap_addr_reg;
  logic [1:0]                cap_size_reg;
  logic                      cap_unsigned_reg;
  logic                      cap_regwrite_reg;
  logic [1:0]                cap_off_reg;

  logic                      wen_reg;
  logic [REG_ADDR_WIDTH-1:0] waddr_reg;
  logic [DATA_WIDTH-1:0]     wdata_reg;
  logic                      lerr_reg;

  // Datapath select signals from the control process.
  logic                      capture;
  logic                      do_write;
  logic                      timeout;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic                      sel_regwrite;
  logic [DATA_WIDTH-1:0]     sel_data;

  // Load-extension inputs: live fields in IDLE, captured fields in WAIT_LOAD.
  logic [1:0]                ld_size;
  logic                      ld_unsigned;
  logic [1:0]                ld_off;
  logic [15:0]               ld_half;
  logic [7:0]                ld_byte;
  logic [DATA_WIDTH-1:0]     ld_ext;

  // Byte lanes of the low word of the load data.
  logic [7:0]                lane [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = readData[8*gi +: 8];
  end

  always_comb begin
    ld_size     = writeBackControl[3:2];
    ld_unsigned = writeBackControl[4];
    ld_off      = byteOffset;
    if (state_reg == WAIT_LOAD) begin
      ld_size     = cap_size_reg;
      ld_unsigned = cap_unsigned_reg;
      ld_off      = cap_off_reg;
    end

    // Half loads only look at offset bit 1; bit 0 is ignored, no fault.
    ld_half = ld_off[1] ? readData[31:16] : readData[15:0];
    ld_byte = lane[ld_off];

    ld_ext = readData;
    case (ld_size)
      2'b01:   ld_ext = {{(DATA_WIDTH-16){~ld_unsigned & ld_half[15]}}, ld_half};
      2'b10:   ld_ext = {{(DATA_WIDTH-8){~ld_unsigned & ld_byte[7]}}, ld_byte};
      default: ld_ext = readData;
    endcase
  end

  // Next-state and control.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    capture      = 1'b0;
    do_write     = 1'b0;
    timeout      = 1'b0;
    stall        = 1'b0;
    sel_addr     = writeReg;
    sel_regwrite = writeBackControl[1];
    sel_data     = result;

    case (state_reg)
      IDLE: begin
        if (inValid) begin
          if (!writeBackControl[0]) begin
            do_write = 1'b1;
          end else if (readValid) begin
            do_write = 1'b1;
            sel_data = ld_ext;
          end else begin
            capture    = 1'b1;
            cnt_next   = '0;
            stall      = 1'b1;
            state_next = WAIT_LOAD;
          end
        end
      end

      WAIT_LOAD: begin
        sel_addr     = cap_addr_reg;
        sel_regwrite = cap_regwrite_reg;
        sel_data     = ld_ext;
        if (readValid) begin
          // Data wins even in the cycle the counter sits at the limit.
          do_write   = 1'b1;
          state_next = IDLE;
        end else begin
          stall = 1'b1;
          if (cnt_reg == TIMEOUT_VAL) begin
            timeout    = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      cap_addr_reg     <= '0;
      cap_size_reg     <= '0;
      cap_unsigned_reg <= 1'b0;
      cap_regwrite_reg <= 1'b0;
      cap_off_reg      <= '0;
      wen_reg          <= 1'b0;
      waddr_reg        <= '0;
      wdata_reg        <= '0;
      lerr_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        cap_addr_reg     <= writeReg;
        cap_size_reg     <= writeBackControl[3:2];
        cap_unsigned_reg <= writeBackControl[4];
        cap_regwrite_reg <= writeBackControl[1];
        cap_off_reg      <= byteOffset;
      end
      // Register 0 is never written, but address and data still follow.
      wen_reg <= do_write & sel_regwrite & (sel_addr != '0);
      if (do_write) begin
        waddr_reg <= sel_addr;
        wdata_reg <= sel_data;
      end
      lerr_reg <= timeout;
    end
  end

  assign regWriteEnable = wen_reg;
  assign regWriteAddr   = waddr_reg;
  assign writeData      = wdata_reg;
  assign loadError      = lerr_reg;

endmodule

// File: tb/tb_write_back_unit.sv
// ---------------------------------------------------------------------------
// tb_write_back_unit
//
// Directed and randomized stimulus for write_back_unit.  A 32-bit instance
// (LOAD_TIMEOUT=4) covers ALU writes, same-cycle and delayed loads, timeout,
// register 0 and reset during a pending load.  A 64-bit instance covers wide
// sign extension.  Expected values come from a shift/mask load model.
// ---------------------------------------------------------------------------
module tb_write_back_unit;

  localparam int LT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_inValid, a_readValid, a_stall, a_wen, a_lerr;
  logic [4:0]  a_ctrl, a_writeReg, a_waddr;
  logic [31:0] a_result, a_readData, a_wdata;
  logic [1:0]  a_off;

  // 64-bit instance
  logic        b_inValid, b_readValid, b_stall, b_wen, b_lerr;
  logic [4:0]  b_ctrl, b_writeReg, b_waddr;
  logic [63:0] b_result, b_readData, b_wdata;
  logic [1:0]  b_off;

  int checks = 0;
  int errors = 0;

  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  write_back_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .LOAD_TIMEOUT(LT)) dut32 (
    .clk(clk), .reset(reset), .inValid(a_inValid), .writeBackControl(a_ctrl),
    .writeReg(a_writeReg), .result(a_result), .readData(a_readData),
    .readValid(a_readValid), .byteOffset(a_off), .stall(a_stall),
    .regWriteEnable(a_wen), .regWriteAddr(a_waddr), .writeData(a_wdata),
    .loadError(a_lerr)
  );

  write_back_unit #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .LOAD_TIMEOUT(15)) dut64 (
    .clk(clk), .reset(reset), .inValid(b_inValid), .writeBackControl(b_ctrl),
    .writeReg(b_writeReg), .result(b_result), .readData(b_readData),
    .readValid(b_readValid), .byteOffset(b_off), .stall(b_stall),
    .regWriteEnable(b_wen), .regWriteAddr(b_waddr), .writeData(b_wdata),
    .loadError(b_lerr)
  );

  // Reference load extension: shift the addressed field down, mask it,
  // then fill the upper bits with ones if it is a signed negative value.
  function automatic logic [63:0] ext_ref(input logic [63:0] rd, input logic [4:0] ctrl,
                                          input logic [1:0] off, input int dw);
    int bits, shift;
    logic [63:0] mask, v, dwmask;
    dwmask = (dw == 64) ? {64{1'b1}} : ((64'd1 << dw) - 64'd1);
    case (ctrl[3:2])
      2'b01: begin bits = 16; shift = off[1] ? 16 : 0; end
      2'b10: begin bits = 8;  shift = 8 * int'(off); end
      default: return rd & dwmask;
    endcase
    mask = (64'd1 << bits) - 64'd1;
    v = (rd >> shift) & mask;
    if (!ctrl[4] && v[bits-1]) v = v | ~mask;
    return v & dwmask;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wen"},  a_wen,   1'b0);
    chk({tag, "_lerr"}, a_lerr,  1'b0);
    chk({tag, "_addr"}, a_waddr, exp_addr);
    chk({tag, "_data"}, a_wdata, exp_data);
  endtask

  task automatic alu_op(input logic [4:0] wr, input logic [31:0] res, input logic rw);
    a_inValid   = 1'b1;
    a_ctrl      = {3'($urandom), rw, 1'b0};
    a_writeReg  = wr;
    a_result    = res;
    a_readValid = 1'($urandom);
    a_readData  = $urandom;
    #1 chk("alu_stall", a_stall, 1'b0);
    tick();
    a_inValid   = 1'b0;
    a_readValid = 1'b0;
    exp_addr = wr;
    exp_data = res;
    chk("alu_wen",  a_wen,   (rw && wr != 5'd0));
    chk("alu_addr", a_waddr, exp_addr);
    chk("alu_data", a_wdata, exp_data);
    chk("alu_lerr", a_lerr,  1'b0);
    $display("ALU  rd=%0d rw=%0b data=%h", wr, rw, res);
  endtask

  // delay = cycles readValid stays low before data arrives (0 = same cycle).
  task automatic load_op(input logic [4:0] wr, input logic [4:0] ctrl, input logic [1:0] off,
                         input logic [31:0] rd, input int delay);
    logic [63:0] e;
    a_inValid  = 1'b1;
    a_ctrl     = ctrl;
    a_writeReg = wr;
    a_off      = off;
    a_result   = $urandom;
    for (int i = 0; i < delay; i++) begin
      a_readValid = 1'b0;
      a_readData  = $urandom;
      #1 chk("ld_stall_hi", a_stall, 1'b1);
      tick();
      chk_idle_outputs("ld_wait");
      // Live fields must no longer matter once the load is pending.
      a_inValid  = 1'($urandom);
      a_ctrl     = 5'($urandom);
      a_writeReg = 5'($urandom);
      a_off      = 2'($urandom);
    end
    a_readValid = 1'b1;
    a_readData  = rd;
    #1 chk("ld_stall_lo", a_stall, 1'b0);
    tick();
    a_inValid   = 1'b0;
    a_readValid = 1'b0;
    e = ext_ref({32'd0, rd}, ctrl, off, 32);
    exp_addr = wr;
    exp_data = e[31:0];
    chk("ld_wen",  a_wen,   (ctrl[1] && wr != 5'd0));
    chk("ld_addr", a_waddr, exp_addr);
    chk("ld_data", a_wdata, exp_data);
    chk("ld_lerr", a_lerr,  1'b0);
    $display("LOAD rd=%0d ctrl=%b off=%0d delay=%0d raw=%h data=%h", wr, ctrl, off, delay, rd, exp_data);
  endtask

  // Load whose data never arrives: LT+2 stall cycles (the capture cycle plus
  // counter values 0..LT), then loadError in the following cycle.
  task automatic timeout_op(input logic [4:0] wr, input logic [4:0] ctrl);
    a_inValid  = 1'b1;
    a_ctrl     = ctrl;
    a_writeReg = wr;
    a_off      = 2'($urandom);
    for (int i = 0; i < LT + 2; i++) begin
      a_readValid = 1'b0;
      a_readData  = $urandom;
      #1 chk("to_stall_hi", a_stall, 1'b1);
      tick();
      chk("to_wen",  a_wen,   1'b0);
      chk("to_lerr", a_lerr,  (i == LT + 1));
      chk("to_addr", a_waddr, exp_addr);
      chk("to_data", a_wdata, exp_data);
    end
    a_inValid = 1'b0;
    #1 chk("to_stall_lo", a_stall, 1'b0);
    tick();
    chk("to_lerr_end", a_lerr, 1'b0);
    $display("TIMEOUT rd=%0d loadError pulsed after %0d stall cycles", wr, LT + 2);
  endtask

  initial begin
    reset = 1'b1;
    a_inValid = 0; a_readValid = 0; a_ctrl = 0; a_writeReg = 0;
    a_result = 0; a_readData = 0; a_off = 0;
    b_inValid = 0; b_readValid = 0; b_ctrl = 0; b_writeReg = 0;
    b_result = 0; b_readData = 0; b_off = 0;
    exp_addr = 0; exp_data = 0;
    tick();
    tick();
    reset = 1'b0;
    chk_idle_outputs("reset");
    chk("reset_stall", a_stall, 1'b0);
    $display("RESET outputs cleared");

    // Basic ALU write.
    alu_op(5'd3, 32'h12345678, 1'b1);
    // Signed byte loads with same-cycle data.
    load_op(5'd7, 5'b0_10_11, 2'd2, 32'h80FF7F01, 0);
    chk("byte_lane2", a_wdata, 32'hFFFFFFFF);
    load_op(5'd7, 5'b0_10_11, 2'd1, 32'h80FF7F01, 0);
    chk("byte_lane1", a_wdata, 32'h0000007F);
    // Delayed unsigned half load: three stall cycles then one write.
    load_op(5'd5, 5'b1_01_11, 2'd0, 32'h0000ABCD, 3);
    chk("half_delayed", a_wdata, 32'h0000ABCD);
    // Signed half, upper lane, offset bit 0 ignored.
    load_op(5'd9, 5'b0_01_11, 2'd3, 32'h8001_1234, 0);
    chk("half_hi", a_wdata, 32'hFFFF8001);
    // Data arriving exactly when the counter is at the limit still writes.
    load_op(5'd11, 5'b0_00_11, 2'd0, 32'hCAFEF00D, LT + 1);
    // Missing load times out, then a normal ALU op.
    timeout_op(5'd12, 5'b0_00_11);
    alu_op(5'd13, 32'hDEADBEEF, 1'b1);
    // Register 0 is never written.
    alu_op(5'd0, 32'h55AA55AA, 1'b1);
    load_op(5'd0, 5'b0_00_11, 2'd0, 32'h11112222, 2);

    // Reset while waiting for load data abandons the load.
    a_inValid = 1'b1; a_ctrl = 5'b0_00_11; a_writeReg = 5'd6; a_readValid = 1'b0;
    tick();
    reset = 1'b1; a_inValid = 1'b0;
    tick();
    reset = 1'b0;
    exp_addr = 0; exp_data = 0;
    chk_idle_outputs("rst_wait");
    chk("rst_wait_stall", a_stall, 1'b0);
    a_readValid = 1'b1; a_readData = $urandom;
    tick();
    a_readValid = 1'b0;
    chk_idle_outputs("stray_rv");
    $display("RESET during WAIT_LOAD: load abandoned");

    // Randomized mix.
    for (int n = 0; n < 40; n++) begin
      logic [4:0] wr;
      wr = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
      case ($urandom_range(0, 2))
        0: alu_op(wr, $urandom, 1'($urandom));
        default: load_op(wr, {2'($urandom), 1'($urandom), 1'($urandom), 1'b1}, 2'($urandom),
                         $urandom, $urandom_range(0, LT + 1));
      endcase
    end

    // 64-bit build: signed half and full-word load.
    b_inValid = 1'b1; b_ctrl = 5'b0_01_11; b_writeReg = 5'd9; b_off = 2'd0;
    b_readValid = 1'b1; b_readData = {32'($urandom), 32'h5A5A8000};
    #1 chk("w64_stall", b_stall, 1'b0);
    tick();
    chk("w64_half_ref", b_wdata, ext_ref(b_readData, b_ctrl, b_off, 64));
    chk("w64_half", b_wdata, 64'hFFFFFFFFFFFF8000);
    chk("w64_wen", b_wen, 1'b1);
    $display("LOAD64 half signed data=%h", b_wdata);
    b_ctrl = 5'b0_00_11; b_readData = {32'($urandom), 32'($urandom)};
    tick();
    chk("w64_word", b_wdata, ext_ref(b_readData, b_ctrl, b_off, 64));
    $display("LOAD64 word data=%h", b_wdata);
    b_inValid = 1'b0; b_readValid = 1'b0;
    tick();
    chk("w64_wen_low", b_wen, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
